// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package pipe_mem_arbiter_pkg;

    localparam int MaxDataBurst = 4;
    localparam int MemTimeout   = 16;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_M,
        SERVE_IF,
        RESP
    } ArbState;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } Mem_req;

endpackage

// File: rtl/pipe_mem_arbiter_watchdog.sv
// Cycle counter bounding how long a memory access may stay outstanding.
module arb_watchdog #(
    parameter int Timeout = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int CW = $clog2(Timeout + 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    // Flags the final permitted cycle so the FSM can leave on this edge.
    assign w_last    = (r_cnt == CW'(Timeout - 1));
    assign o_expired = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count && !w_last) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory,
// with fetch anti-starvation and a watchdog on memory completion.
module pipe_mem_arbiter #(
    parameter int MaxDataBurst = pipe_mem_arbiter_pkg::MaxDataBurst,
    parameter int MemTimeout   = pipe_mem_arbiter_pkg::MemTimeout
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        m_read,
    input  logic        m_write,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_ready,
    output logic [31:0] m_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_m,
    output logic        err
);

    import pipe_mem_arbiter_pkg::*;

    localparam int SW = $clog2(MaxDataBurst + 1);

    ArbState       r_state;
    Mem_req        r_req;
    logic          r_mem_req;
    logic          r_if_ready;
    logic          r_m_ready;
    logic          r_err;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_m_rdata;
    logic [SW-1:0] r_streak;

    logic w_m_any;
    logic w_grant_if;
    logic w_serving;
    logic w_idle;
    logic w_expired;
    logic w_unused;

    assign w_m_any    = m_read | m_write;
    assign w_grant_if = if_req & (~w_m_any | (r_streak == SW'(MaxDataBurst)));
    assign w_serving  = (r_state == SERVE_M) | (r_state == SERVE_IF);
    assign w_idle     = (r_state == IDLE);
    assign w_unused   = ^m_addr[31:8];

    arb_watchdog #(
        .Timeout(MemTimeout)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_idle),
        .i_count  (w_serving),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_mem_req  <= 1'b0;
            r_if_ready <= 1'b0;
            r_m_ready  <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_m_rdata  <= '0;
            r_streak   <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_m_ready  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_if) begin
                        r_state    <= SERVE_IF;
                        r_req.we   <= 1'b0;
                        r_req.addr <= if_addr;
                        r_mem_req  <= 1'b1;
                        r_streak   <= '0;
                    end else if (w_m_any) begin
                        r_state   <= SERVE_M;
                        r_req     <= '{we: m_write, addr: m_addr[7:0],
                                       wdata: m_wdata};
                        r_mem_req <= 1'b1;
                        r_streak  <= if_req ? r_streak + SW'(1) : '0;
                    end
                end
                SERVE_M, SERVE_IF: begin
                    if (mem_ack || w_expired) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        r_req.we  <= 1'b0;
                        if (!mem_ack) begin
                            r_err <= 1'b1;
                        end
                        if (r_state == SERVE_IF) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            r_m_ready <= 1'b1;
                            // A completed write leaves the load data alone.
                            if (!mem_ack) begin
                                r_m_rdata <= '0;
                            end else if (!r_req.we) begin
                                r_m_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign m_ready   = r_m_ready;
    assign m_rdata   = r_m_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_req.we;
    assign mem_addr  = r_req.addr;
    assign mem_wdata = r_req.wdata;
    assign err       = r_err;
    assign stall_if  = if_req & ~r_if_ready;
    assign stall_m   = w_m_any & ~r_m_ready;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: fetch, data, starvation,
// timeout and reset-abort scenarios against hand-derived values.
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_m;
    logic        err;

    logic        ack_en;
    logic        ack_force;
    logic [31:0] rdata_val;

    int n_chk  = 0;
    int n_pass = 0;

    assign mem_ack   = (mem_req & ack_en) | ack_force;
    assign mem_rdata = rdata_val;

    always #5 clk = ~clk;

    pipe_mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .m_read   (m_read),
        .m_write  (m_write),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_m  (stall_m),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   serve;
        logic done;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        m_read = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
        ack_en = 1'b0; ack_force = 1'b0; rdata_val = '0;
        tick; tick;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_if_ready", 32'(if_ready), 0);
        chk("rst_m_ready", 32'(m_ready), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        tick;

        // stray ack while idle
        ack_force = 1'b1;
        tick; tick;
        chk("stray_if_ready", 32'(if_ready), 0);
        chk("stray_m_ready", 32'(m_ready), 0);
        chk("stray_mem_req", 32'(mem_req), 0);
        ack_force = 1'b0;
        tick;

        // fetch only, minimum latency
        ack_en = 1'b1; rdata_val = 32'h2002000A;
        if_req = 1'b1; if_addr = 8'h10;
        #1 chk("f_stall_n", 32'(stall_if), 1);
        tick;
        chk("f_mem_req", 32'(mem_req), 1);
        chk("f_mem_addr", 32'(mem_addr), 32'h10);
        chk("f_mem_we", 32'(mem_we), 0);
        chk("f_stall_n1", 32'(stall_if), 1);
        chk("f_ready_n1", 32'(if_ready), 0);
        tick;
        chk("f_ready", 32'(if_ready), 1);
        chk("f_rdata", if_rdata, 32'h2002000A);
        chk("f_stall_n2", 32'(stall_if), 0);
        if_req = 1'b0;
        tick;
        chk("f_ready_pulse", 32'(if_ready), 0);
        chk("f_mem_req_off", 32'(mem_req), 0);

        // simultaneous: data first, fetch next
        if_req = 1'b1; if_addr = 8'h14;
        m_read = 1'b1; m_addr = 32'h0000_0120; rdata_val = 32'h11112222;
        #1 chk("s_stall_m", 32'(stall_m), 1);
        tick;
        chk("s_m_addr", 32'(mem_addr), 32'h20);
        chk("s_m_we", 32'(mem_we), 0);
        tick;
        chk("s_m_ready", 32'(m_ready), 1);
        chk("s_m_rdata", m_rdata, 32'h11112222);
        chk("s_if_ready", 32'(if_ready), 0);
        m_read = 1'b0; rdata_val = 32'h33334444;
        tick;
        chk("s_idle", 32'(mem_req), 0);
        tick;
        chk("s_f_req", 32'(mem_req), 1);
        chk("s_f_addr", 32'(mem_addr), 32'h14);
        tick;
        chk("s_f_ready", 32'(if_ready), 1);
        chk("s_f_rdata", if_rdata, 32'h33334444);
        if_req = 1'b0;
        tick;

        // starvation with writes
        m_write = 1'b1; m_addr = 32'h104; m_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 8'h30; rdata_val = 32'h55556666;
        for (int g = 0; g < 5; g++) begin
            tick;
            chk("st_we", 32'(mem_we), (g < 4) ? 1 : 0);
            if (g < 4) begin
                chk("w_addr", 32'(mem_addr), 32'h04);
                chk("w_wdata", mem_wdata, 32'hDEADBEEF);
            end else begin
                chk("st_f_addr", 32'(mem_addr), 32'h30);
                chk("st_streak", 32'(dut.r_streak), 0);
            end
            tick;
            if (g < 4) begin
                chk("st_m_ready", 32'(m_ready), 1);
            end else begin
                chk("st_if_ready", 32'(if_ready), 1);
                if_req = 1'b0;
            end
            tick;
        end
        m_write = 1'b0;
        chk("w_m_rdata_kept", m_rdata, 32'h11112222);
        tick;

        // timeout on a read
        ack_en = 1'b0; m_read = 1'b1; m_addr = 32'h40;
        serve = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick;
            if (m_ready) done = 1'b1;
            else if (mem_req) serve++;
        end
        chk("to_ready", 32'(done), 1);
        chk("to_cycles", 32'(serve), 16);
        chk("to_rdata", m_rdata, 0);
        chk("to_err", 32'(err), 1);
        m_read = 1'b0;
        tick;

        // later access keeps err
        ack_en = 1'b1; rdata_val = 32'h0BADF00D; m_read = 1'b1; m_addr = 32'h08;
        tick; tick;
        chk("ok_m_ready", 32'(m_ready), 1);
        chk("ok_m_rdata", m_rdata, 32'h0BADF00D);
        chk("err_sticky", 32'(err), 1);
        m_read = 1'b0;
        tick;

        // reset during SERVE_IF
        ack_en = 1'b0; if_req = 1'b1; if_addr = 8'h44;
        tick;
        chk("ra_mem_req", 32'(mem_req), 1);
        #1 rst = 1'b1;
        #1 chk("ra_abort", 32'(mem_req), 0);
        chk("ra_err_clr", 32'(err), 0);
        tick;
        chk("ra_no_ready0", 32'(if_ready), 0);
        tick;
        chk("ra_no_ready1", 32'(if_ready), 0);
        rst = 1'b0; ack_en = 1'b1; rdata_val = 32'h77778888;
        tick;
        chk("ra_reissue", 32'(mem_req), 1);
        chk("ra_addr", 32'(mem_addr), 32'h44);
        tick;
        chk("ra_ready", 32'(if_ready), 1);
        chk("ra_rdata", if_rdata, 32'h77778888);
        if_req = 1'b0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
